// File: rtl/axis_rx_rr_arbiter.sv
// Packet-granular round-robin arbiter merging NUM_SRC AXI-Stream RX sources
// onto one registered output; m_tid carries the winning source index.
module axis_rx_rr_arbiter #(
   parameter int DATA_WIDTH = 64,
   parameter int NUM_SRC    = 4
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic [NUM_SRC-1:0]              src_en,
   input  logic [NUM_SRC-1:0]              s_tvalid,
   input  logic [NUM_SRC*DATA_WIDTH-1:0]   s_tdata,
   input  logic [NUM_SRC*DATA_WIDTH/8-1:0] s_tkeep,
   input  logic [NUM_SRC-1:0]              s_tlast,
   output logic [NUM_SRC-1:0]              s_tready,
   output logic                            m_tvalid,
   output logic [DATA_WIDTH-1:0]           m_tdata,
   output logic [DATA_WIDTH/8-1:0]         m_tkeep,
   output logic                            m_tlast,
   output logic [$clog2(NUM_SRC)-1:0]      m_tid,
   input  logic                            m_tready,
   output logic                            busy
);

   localparam int KW = DATA_WIDTH / 8;
   localparam int IW = $clog2(NUM_SRC);

   // Handshake: a beat moves on a port when its tvalid and tready are both
   // high at a rising clk edge; tvalid never waits on tready.
   typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

   state_t            state_q, state_d;
   logic [IW-1:0]     grant_q, grant_d;
   logic [IW-1:0]     rr_ptr_q, rr_ptr_d;
   logic              m_tvalid_q, m_tvalid_d;
   logic [DATA_WIDTH-1:0] m_tdata_q, m_tdata_d;
   logic [KW-1:0]     m_tkeep_q, m_tkeep_d;
   logic              m_tlast_q, m_tlast_d;
   logic [IW-1:0]     m_tid_q, m_tid_d;

   logic [NUM_SRC-1:0] req;
   logic               sel_found;
   logic [IW-1:0]      sel_idx;
   logic [IW-1:0]      cand;
   logic               out_rdy;
   logic               accept;
   logic [NUM_SRC-1:0] s_tready_c;

   assign req     = s_tvalid & src_en;
   assign out_rdy = !m_tvalid_q || m_tready;

   // First requester strictly after rr_ptr, wrapping modulo NUM_SRC.
   always_comb begin
      sel_found = 1'b0;
      sel_idx   = '0;
      cand      = '0;
      for (int k = 1; k <= NUM_SRC; k++) begin
         cand = IW'((int'(rr_ptr_q) + k) % NUM_SRC);
         if (!sel_found && req[cand]) begin
            sel_found = 1'b1;
            sel_idx   = cand;
         end
      end
   end

   always_comb begin
      s_tready_c = '0;
      accept     = 1'b0;
      if (state_q == BUSY) begin
         s_tready_c[grant_q] = out_rdy;
         accept              = s_tvalid[grant_q] && out_rdy;
      end
   end

   always_comb begin
      state_d  = state_q;
      grant_d  = grant_q;
      rr_ptr_d = rr_ptr_q;
      case (state_q)
         IDLE: begin
            if (sel_found) begin
               grant_d = sel_idx;
               state_d = BUSY;
            end
         end
         BUSY: begin
            if (accept && s_tlast[grant_q]) begin
               state_d  = IDLE;
               rr_ptr_d = grant_q;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      m_tvalid_d = m_tvalid_q;
      m_tdata_d  = m_tdata_q;
      m_tkeep_d  = m_tkeep_q;
      m_tlast_d  = m_tlast_q;
      m_tid_d    = m_tid_q;
      if (accept) begin
         m_tvalid_d = 1'b1;
         m_tdata_d  = s_tdata[grant_q*DATA_WIDTH +: DATA_WIDTH];
         m_tkeep_d  = s_tkeep[grant_q*KW +: KW];
         m_tlast_d  = s_tlast[grant_q];
         m_tid_d    = grant_q;
      end else if (m_tready) begin
         m_tvalid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         grant_q    <= '0;
         rr_ptr_q   <= IW'(NUM_SRC - 1);
         m_tvalid_q <= 1'b0;
         m_tdata_q  <= '0;
         m_tkeep_q  <= '0;
         m_tlast_q  <= 1'b0;
         m_tid_q    <= '0;
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         rr_ptr_q   <= rr_ptr_d;
         m_tvalid_q <= m_tvalid_d;
         m_tdata_q  <= m_tdata_d;
         m_tkeep_q  <= m_tkeep_d;
         m_tlast_q  <= m_tlast_d;
         m_tid_q    <= m_tid_d;
      end
   end

   assign s_tready = s_tready_c;
   assign m_tvalid = m_tvalid_q;
   assign m_tdata  = m_tdata_q;
   assign m_tkeep  = m_tkeep_q;
   assign m_tlast  = m_tlast_q;
   assign m_tid    = m_tid_q;
   assign busy     = (state_q == BUSY);

endmodule

// File: tb/tb_axis_rx_rr_arbiter.sv
// Directed bench for axis_rx_rr_arbiter: per-source beat queues feed the DUT,
// hand-ordered expected output beats sit in exp_q and are compared as they appear.
module tb_axis_rx_rr_arbiter;

   localparam int DW = 64;
   localparam int NS = 4;
   localparam int KW = DW / 8;

   typedef struct packed {
      logic [DW-1:0] data;
      logic [KW-1:0] keep;
      logic          last;
   } beat_t;

   logic              clk;
   logic              rst_n;
   logic [NS-1:0]     src_en;
   logic [NS-1:0]     s_tvalid;
   logic [NS*DW-1:0]  s_tdata;
   logic [NS*KW-1:0]  s_tkeep;
   logic [NS-1:0]     s_tlast;
   logic [NS-1:0]     s_tready;
   logic              m_tvalid;
   logic [DW-1:0]     m_tdata;
   logic [KW-1:0]     m_tkeep;
   logic              m_tlast;
   logic [1:0]        m_tid;
   logic              m_tready;
   logic              busy;

   axis_rx_rr_arbiter #(.DATA_WIDTH(DW), .NUM_SRC(NS)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .src_en   (src_en),
      .s_tvalid (s_tvalid),
      .s_tdata  (s_tdata),
      .s_tkeep  (s_tkeep),
      .s_tlast  (s_tlast),
      .s_tready (s_tready),
      .m_tvalid (m_tvalid),
      .m_tdata  (m_tdata),
      .m_tkeep  (m_tkeep),
      .m_tlast  (m_tlast),
      .m_tid    (m_tid),
      .m_tready (m_tready),
      .busy     (busy)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- bench state ----------------
   int            n_vec = 0;
   int            n_err = 0;
   int            cyc   = 0;
   beat_t         src_q[NS][$];
   logic [79:0]   exp_q[$];
   int            acc_cyc[$];
   logic [NS-1:0] acc = '0;
   logic          tready_drv = 1'b1;
   logic [NS-1:0] en_drv = '1;

   task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic beat_t mk_beat(input logic [7:0] base, input int b, input int n,
                                     input logic [7:0] lastkeep);
      beat_t    bt;
      logic [7:0] by;
      by      = base + 8'(b * 17);
      bt.data = {8{by}};
      bt.keep = (b == n - 1) ? lastkeep : 8'hFF;
      bt.last = (b == n - 1);
      return bt;
   endfunction

   function automatic logic [79:0] pk(input int tid, input beat_t bt);
      return {4'b0, 3'(tid), bt.last, bt.keep, bt.data};
   endfunction

   task automatic load_pkt(input int src, input int n, input logic [7:0] base,
                           input logic [7:0] lastkeep);
      for (int b = 0; b < n; b++) src_q[src].push_back(mk_beat(base, b, n, lastkeep));
   endtask

   task automatic expect_pkt(input int src, input int n, input logic [7:0] base,
                             input logic [7:0] lastkeep);
      for (int b = 0; b < n; b++) exp_q.push_back(pk(src, mk_beat(base, b, n, lastkeep)));
   endtask

   // ---------------- driver ----------------
   task automatic drive();
      for (int i = 0; i < NS; i++) begin
         if (src_q[i].size() != 0) begin
            s_tvalid[i]           = 1'b1;
            s_tdata[i*DW +: DW]   = src_q[i][0].data;
            s_tkeep[i*KW +: KW]   = src_q[i][0].keep;
            s_tlast[i]            = src_q[i][0].last;
         end else begin
            s_tvalid[i]           = 1'b0;
            s_tdata[i*DW +: DW]   = '0;
            s_tkeep[i*KW +: KW]   = '0;
            s_tlast[i]            = 1'b0;
         end
      end
      m_tready = tready_drv;
      src_en   = en_drv;
   endtask

   // ---------------- scoreboard / monitor (negedge) ----------------
   task automatic sample();
      logic [79:0] obs;
      obs = {5'b0, m_tid, m_tlast, m_tkeep, m_tdata};
      if (m_tvalid) begin
         if (exp_q.size() == 0) begin
            check("extra_beat", 80'(exp_q.size()), 80'd1);
         end else begin
            check("beat", obs, exp_q[0]);
            if (m_tready) void'(exp_q.pop_front());
         end
      end
      check("tready_1hot", 80'($onehot0(s_tready)), 80'd1);
      acc = s_tvalid & s_tready;
      if (|acc) acc_cyc.push_back(cyc);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
      for (int i = 0; i < NS; i++)
         if (acc[i] && src_q[i].size() != 0) void'(src_q[i].pop_front());
      drive();
      @(negedge clk);
      sample();
   endtask

   task automatic wait_drain(input string tag);
      for (int k = 0; k < 200; k++) begin
         if (exp_q.size() == 0 && !m_tvalid && !busy) break;
         step();
      end
      check(tag, 80'(exp_q.size()), 80'd0);
   endtask

   task automatic clear_all();
      for (int i = 0; i < NS; i++) src_q[i].delete();
      exp_q.delete();
      acc = '0;
      drive();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      clear_all();
      @(negedge clk);
      check("rst_m_tvalid", 80'(m_tvalid), 80'd0);
      check("rst_m_tdata",  80'(m_tdata),  80'd0);
      check("rst_m_tkeep",  80'(m_tkeep),  80'd0);
      check("rst_m_tlast",  80'(m_tlast),  80'd0);
      check("rst_m_tid",    80'(m_tid),    80'd0);
      check("rst_busy",     80'(busy),     80'd0);
      check("rst_s_tready", 80'(s_tready), 80'd0);
      @(posedge clk);
      #2;
      rst_n = 1'b1;
   endtask

   // ---------------- directed tests ----------------
   initial begin
      rst_n    = 1'b0;
      s_tvalid = '0;
      s_tdata  = '0;
      s_tkeep  = '0;
      s_tlast  = '0;
      m_tready = 1'b1;
      src_en   = '1;
      do_reset();

      // T1: single 3-beat packet from source 0
      load_pkt(0, 3, 8'h11, 8'hFF);
      expect_pkt(0, 3, 8'h11, 8'hFF);
      step();
      check("t1_idle_rdy", 80'(s_tready), 80'd0);
      step();
      check("t1_rdy",  80'(s_tready), 80'b0001);
      check("t1_busy", 80'(busy), 80'd1);
      for (int k = 0; k < 20 && src_q[0].size() != 0; k++) step();
      check("t1_busy_end", 80'(busy), 80'd0);
      wait_drain("t1_drain");

      // T2: sources 1 and 2 stream 2-beat packets from reset -> 1,2,1,2,1,2
      do_reset();
      acc_cyc.delete();
      for (int j = 0; j < 3; j++) begin
         load_pkt(1, 2, 8'(8'h40 + 8'(j * 32)), 8'h0F);
         load_pkt(2, 2, 8'(8'h50 + 8'(j * 32)), 8'h01);
      end
      for (int j = 0; j < 3; j++) begin
         expect_pkt(1, 2, 8'(8'h40 + 8'(j * 32)), 8'h0F);
         expect_pkt(2, 2, 8'(8'h50 + 8'(j * 32)), 8'h01);
      end
      wait_drain("t2_drain");
      check("t2_naccept", 80'(acc_cyc.size()), 80'd12);
      for (int j = 0; j + 1 < acc_cyc.size(); j++)
         check("t2_gap", 80'(acc_cyc[j+1] - acc_cyc[j]), (j % 2 == 0) ? 80'd1 : 80'd2);

      // T3: source 3 alone, then 0 and 3 together -> 0 wins by wrap-around
      load_pkt(3, 2, 8'hA0, 8'h3F);
      expect_pkt(3, 2, 8'hA0, 8'h3F);
      wait_drain("t3_drain_a");
      load_pkt(0, 2, 8'hB0, 8'h07);
      load_pkt(3, 2, 8'hC0, 8'hFF);
      expect_pkt(0, 2, 8'hB0, 8'h07);
      expect_pkt(3, 2, 8'hC0, 8'hFF);
      wait_drain("t3_drain_b");

      // T4: 4-cycle downstream stall mid-packet on source 1
      load_pkt(1, 4, 8'h60, 8'h1F);
      expect_pkt(1, 4, 8'h60, 8'h1F);
      for (int k = 0; k < 20 && !m_tvalid; k++) step();
      check("t4_first_out", 80'(m_tvalid), 80'd1);
      tready_drv = 1'b0;
      repeat (4) begin
         step();
         check("t4_stall_rdy",   80'(s_tready), 80'd0);
         check("t4_stall_valid", 80'(m_tvalid), 80'd1);
      end
      tready_drv = 1'b1;
      wait_drain("t4_drain");

      // T5a: src_en=1101, all request -> order 2,3,0; source 1 never ready
      en_drv = 4'b1101;
      load_pkt(0, 2, 8'h70, 8'hFF);
      load_pkt(1, 2, 8'h78, 8'hFF);
      load_pkt(2, 2, 8'h80, 8'h03);
      load_pkt(3, 2, 8'h88, 8'h7F);
      expect_pkt(2, 2, 8'h80, 8'h03);
      expect_pkt(3, 2, 8'h88, 8'h7F);
      expect_pkt(0, 2, 8'h70, 8'hFF);
      for (int k = 0; k < 100; k++) begin
         step();
         check("t5_src1_rdy", 80'(s_tready[1]), 80'd0);
         if (exp_q.size() == 0 && !m_tvalid && !busy) break;
      end
      check("t5_drain", 80'(exp_q.size()), 80'd0);
      check("t5_src1_held", 80'(src_q[1].size()), 80'd2);
      src_q[1].delete();
      step();
      en_drv = '1;

      // T5b: src_en[0] dropped mid-packet; packet still completes
      load_pkt(0, 3, 8'h90, 8'h0F);
      expect_pkt(0, 3, 8'h90, 8'h0F);
      for (int k = 0; k < 20 && !busy; k++) step();
      check("t5b_busy", 80'(busy), 80'd1);
      en_drv = 4'b1110;
      wait_drain("t5b_drain");
      en_drv = '1;
      step();

      // T6: reset during beat 2 of a 4-beat packet from source 3
      load_pkt(3, 4, 8'hD0, 8'hFF);
      expect_pkt(3, 4, 8'hD0, 8'hFF);
      for (int k = 0; k < 20 && src_q[3].size() != 3; k++) step();
      check("t6_mid_pkt", 80'(src_q[3].size()), 80'd3);
      rst_n = 1'b0;
      #1;
      check("t6_rst_valid", 80'(m_tvalid), 80'd0);
      check("t6_rst_rdy",   80'(s_tready), 80'd0);
      check("t6_rst_busy",  80'(busy),     80'd0);
      clear_all();
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      load_pkt(0, 2, 8'hE0, 8'hFF);
      load_pkt(2, 2, 8'hE8, 8'h0F);
      expect_pkt(0, 2, 8'hE0, 8'hFF);
      expect_pkt(2, 2, 8'hE8, 8'h0F);
      wait_drain("t6_drain_a");

      do_reset();
      load_pkt(2, 2, 8'hF0, 8'h01);
      expect_pkt(2, 2, 8'hF0, 8'h01);
      step();
      step();
      check("t6_src2_grant", 80'(s_tready), 80'b0100);
      wait_drain("t6_drain_b");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/axis_rx_rr_arbiter.md
Name: axis_rx_rr_arbiter

Overview:
- Shares one AXI-Stream RX datapath (64-bit, tkeep-qualified, tlast-framed) between NUM_SRC upstream sources.
- Arbitration is packet-granular and round-robin: once a source is granted, it owns the output until its tlast beat is accepted.
- A registered output stage decouples downstream backpressure.
- Sits between the MAC/ingress ports and the byte-packing RX receiver; m_tid tells downstream which port a packet came from.

Parameters:
- DATA_WIDTH, 64, data bus width in bits; must be a multiple of 8.
- NUM_SRC, 4, number of source ports; must be 2 to 8.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- src_en  input  NUM_SRC  per-source enable mask; 0 excludes the source from new grants
- s_tvalid  input  NUM_SRC  per-source valid
- s_tdata  input  NUM_SRC*DATA_WIDTH  source i data at [i*DATA_WIDTH +: DATA_WIDTH]
- s_tkeep  input  NUM_SRC*DATA_WIDTH/8  source i keep at [i*DATA_WIDTH/8 +: DATA_WIDTH/8]
- s_tlast  input  NUM_SRC  per-source last
- s_tready  output  NUM_SRC  per-source ready; one-hot or zero
- m_tvalid  output  1  output valid
- m_tdata  output  DATA_WIDTH  output data
- m_tkeep  output  DATA_WIDTH/8  output keep
- m_tlast  output  1  output last
- m_tid  output  $clog2(NUM_SRC)  source index of the current output beat
- m_tready  input  1  downstream ready
- busy  output  1  high while a packet is granted (state BUSY)

Behaviour:
- Reset values (async assert, sync release):
  - m_tvalid=0, m_tdata=0, m_tkeep=0, m_tlast=0, m_tid=0, busy=0, s_tready=0.
  - state=IDLE, grant=0, rr_ptr=NUM_SRC-1, so source 0 has first priority.
- Request vector: req = s_tvalid & src_en.
- State IDLE:
  - If req≠0, select the first set bit of req scanning from rr_ptr+1 upward, wrapping modulo NUM_SRC.
  - Register it into grant and move to BUSY on the next edge.
  - s_tready is all-zero in IDLE, so arbitration costs exactly one cycle.
- State BUSY:
  - s_tready[grant] = (!m_tvalid || m_tready). All other s_tready bits are 0.
  - A beat is accepted when s_tvalid[grant] && s_tready[grant].
- Output register:
  - On an accepted beat, load m_tdata/m_tkeep/m_tlast from the granted slice, set m_tid=grant and m_tvalid=1.
  - Else if m_tready, clear m_tvalid.
  - While m_tvalid && !m_tready, all m_* outputs hold stable.
- Latency: a beat accepted at edge t is visible on m_* after edge t; one beat per cycle sustained within a packet.
- Packet end:
  - When the accepted beat has s_tlast=1, return to IDLE and set rr_ptr=grant on that edge.
  - Next arbitration happens in the following IDLE cycle, so there is one bubble per packet.
- src_en deasserted for the granted source mid-packet: ignored; the packet completes. The mask only affects selection in IDLE.
- s_tvalid dropping mid-packet on the granted source: stay in BUSY, wait; no timeout.
- tkeep passes through unmodified; the arbiter never inspects it.
- A source with s_tvalid=1 but src_en=0 is never granted and sees s_tready=0.
- Simultaneous requests: strict round-robin from rr_ptr+1. Wrap-around example: rr_ptr=NUM_SRC-1 gives source 0 highest priority.
- Reset mid-packet:
  - All state and outputs return to reset values immediately.
  - A partially forwarded packet is truncated. Downstream handles this by also being reset.

Test Plan:
- Source 0 sends 3 beats (0x11..,0x22..,0x33.. with tlast on the third), tkeep=0xFF, m_tready=1 -> s_tready[0] first high one cycle after s_tvalid; m_* shows the 3 beats on consecutive cycles with m_tid=0 and m_tlast on beat 3; busy drops after the last accept.
- Sources 1 and 2 each continuously offer 2-beat packets from reset -> output packet order 1,2,1,2; never interleaved mid-packet; exactly one idle input cycle between packets.
- Source 3 granted and completes; sources 0 and 3 then both request -> source 0 wins (wrap-around); m_tid=0.
- m_tready held low for 4 cycles mid-packet -> m_tdata/m_tkeep/m_tlast/m_tid stable; s_tready[grant]=0 after the output register fills; no beat lost or duplicated on release.
- src_en=4'b1101 with all sources requesting -> source 1 never receives s_tready. Clearing src_en[0] during source 0's packet -> that packet still finishes with tlast.
- rst_n asserted during beat 2 of a 4-beat packet -> m_tvalid=0 and s_tready=0 immediately. After release with source 2 requesting -> source 0 has priority again if it requests; otherwise source 2 is granted cleanly.
